// File: rtl/sap_ir_pkg.sv
// Shared SAP instruction-register types, default widths and helpers.
// Reused by the controller's opcode decode.
package sap_ir_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OPND  = 2'd1,
        FULL  = 2'd2
    } ir_state_e;

    localparam int          DEF_BUS_W      = 8;
    localparam int          DEF_OP_W       = 4;
    localparam int          DEF_ADDR_BYTES = 2;
    localparam logic [15:0] DEF_LONG_MASK  = 16'hFF00;

    // Byte-counter width; at least one bit even for single-byte operands.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sap_ir_opnd_shift.sv
// Byte-lane assembler: address register and operand byte counter.
// Operand bytes are placed little-endian, lowest lane first.
module sap_ir_opnd_shift
    import sap_ir_pkg::*;
#(
    parameter int BUS_W      = DEF_BUS_W,
    parameter int ADDR_BYTES = DEF_ADDR_BYTES,
    localparam int ADDR_W    = BUS_W * ADDR_BYTES,
    localparam int CNT_W     = cnt_w(ADDR_BYTES)
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              zero_ld_i,
    input  logic              start_i,
    input  logic              lane_wr_i,
    input  logic [BUS_W-1:0]  byte_i,
    input  logic [ADDR_W-1:0] imm_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ADDR_BYTES - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (zero_ld_i) begin
            addr_d = imm_i;
            cnt_d  = '0;
        end else if (start_i) begin
            addr_d = '0;
            cnt_d  = '0;
        end else if (lane_wr_i) begin
            addr_d[BUS_W*int'(cnt_q) +: BUS_W] = byte_i;
            // Saturate on the last lane; the next opcode clears it anyway.
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/sap_ir_assembler.sv
// SAP instruction register: opcode capture plus multi-byte operand assembly.
// Macro SAP_IR_TRISTATE_EN floats IR_Add when EI=0 instead of forcing zero.
module sap_ir_assembler
    import sap_ir_pkg::*;
#(
    parameter int BUS_W      = DEF_BUS_W,
    parameter int OP_W       = DEF_OP_W,
    parameter int ADDR_BYTES = DEF_ADDR_BYTES,
    parameter logic [(1<<OP_W)-1:0] LONG_MASK = DEF_LONG_MASK,
    localparam int ADDR_W    = BUS_W * ADDR_BYTES
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              LI,
    input  logic              EI,
    input  logic [BUS_W-1:0]  IR_in,
    output logic [ADDR_W-1:0] IR_Add,
    output logic [OP_W-1:0]   IR_Op_code,
    output logic              IR_ready,
    output logic              IR_need
);

    ir_state_e         state_q;
    logic [OP_W-1:0]   op_q;
    logic              ready_q;
    logic              need_q;
    logic [ADDR_W-1:0] addr;
    logic              last;

    logic [OP_W-1:0] in_op;
    logic            is_long;
    logic            op_cyc;

    assign in_op   = IR_in[BUS_W-1 -: OP_W];
    assign is_long = LONG_MASK[in_op];
    assign op_cyc  = LI && (state_q != OPND);

    sap_ir_opnd_shift #(
        .BUS_W      (BUS_W),
        .ADDR_BYTES (ADDR_BYTES)
    ) u_shift (
        .clk       (clk),
        .clr_i     (clr),
        .zero_ld_i (op_cyc && !is_long),
        .start_i   (op_cyc && is_long),
        .lane_wr_i (LI && (state_q == OPND)),
        .byte_i    (IR_in),
        .imm_i     (ADDR_W'(IR_in[BUS_W-OP_W-1:0])),
        .addr_o    (addr),
        .last_o    (last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EMPTY;
            op_q    <= '0;
            ready_q <= 1'b0;
            need_q  <= 1'b0;
        end else if (LI) begin
            unique case (state_q)
                EMPTY, FULL: begin
                    op_q <= in_op;
                    if (is_long) begin
                        state_q <= OPND;
                        ready_q <= 1'b0;
                        need_q  <= 1'b1;
                    end else begin
                        state_q <= FULL;
                        ready_q <= 1'b1;
                        need_q  <= 1'b0;
                    end
                end
                OPND: begin
                    if (last) begin
                        state_q <= FULL;
                        ready_q <= 1'b1;
                        need_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    ready_q <= 1'b0;
                    need_q  <= 1'b0;
                end
            endcase
        end
    end

    assign IR_Op_code = op_q;
    assign IR_ready   = ready_q;
    assign IR_need    = need_q;

`ifdef SAP_IR_TRISTATE_EN
    assign IR_Add = EI ? addr : 'z;
`else
    assign IR_Add = EI ? addr : '0;
`endif

endmodule

// File: tb/tb_sap_ir_assembler.sv
// Vector-table bench with expectation queue for sap_ir_assembler.
// Covers reset priority, short/long loads, aborts, back-to-back and EI gating.
module tb_sap_ir_assembler;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        LI  = 1'b0;
    logic        EI  = 1'b0;
    logic [7:0]  IR_in = 8'h00;
    logic [15:0] IR_Add;
    logic [3:0]  IR_Op_code;
    logic        IR_ready;
    logic        IR_need;

    sap_ir_assembler dut (
        .clk        (clk),
        .clr        (clr),
        .LI         (LI),
        .EI         (EI),
        .IR_in      (IR_in),
        .IR_Add     (IR_Add),
        .IR_Op_code (IR_Op_code),
        .IR_ready   (IR_ready),
        .IR_need    (IR_need)
    );

    always #5 clk = ~clk;

`ifdef SAP_IR_TRISTATE_EN
    localparam logic [15:0] OFF = 16'hzzzz;
`else
    localparam logic [15:0] OFF = 16'h0000;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] add;
        logic        rdy;
        logic        need;
    } exp_t;

    typedef struct {
        logic       clr;
        logic       li;
        logic       ei;
        logic [7:0] din;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic c, logic l, logic e, logic [7:0] d,
                                logic [3:0] op, logic [15:0] a,
                                logic r, logic n);
        vec_t v;
        v.clr = c; v.li = l; v.ei = e; v.din = d;
        v.exp = '{op: op, add: a, rdy: r, need: n};
        return v;
    endfunction

    task automatic check(string name, exp_t e);
        exp_t act;
        act = '{op: IR_Op_code, add: IR_Add, rdy: IR_ready, need: IR_need};
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got op=%h add=%h rdy=%b need=%b want op=%h add=%h rdy=%b need=%b",
                     name, act.op, act.add, act.rdy, act.need,
                     e.op, e.add, e.rdy, e.need);
        end
    endtask

    task automatic apply(int idx, vec_t v);
        @(negedge clk);
        clr = v.clr; LI = v.li; EI = v.ei; IR_in = v.din;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            check($sformatf("vec%0d", idx), sb.pop_front());
        end
    endtask

    initial begin
        // reset priority over LI
        vecs.push_back(mk(1, 1, 1, 8'h98, 4'h0, 16'h0000, 0, 0));
        // short instruction
        vecs.push_back(mk(0, 1, 1, 8'h3A, 4'h3, 16'h000A, 1, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 4'h0, 16'h0000, 0, 0));
        // long with idle gaps
        vecs.push_back(mk(0, 1, 1, 8'hC5, 4'hC, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'hEE, 4'hC, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h77, 4'hC, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'h34, 4'hC, 16'h0034, 0, 1));
        vecs.push_back(mk(0, 0, 1, 8'h55, 4'hC, 16'h0034, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'h12, 4'hC, 16'h1234, 1, 0));
        // FULL -> short, no bubble
        vecs.push_back(mk(0, 1, 1, 8'h41, 4'h4, 16'h0001, 1, 0));
        // FULL -> long, ready drops
        vecs.push_back(mk(0, 1, 1, 8'hC5, 4'hC, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'h34, 4'hC, 16'h0034, 0, 1));
        // abort partial instruction
        vecs.push_back(mk(1, 0, 1, 8'h00, 4'h0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h27, 4'h2, 16'h0007, 1, 0));
        // EI gating
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'h2, OFF,      1, 0));
        vecs.push_back(mk(0, 0, 1, 8'hFF, 4'h2, 16'h0007, 1, 0));
        // back-to-back long, LI every cycle
        vecs.push_back(mk(0, 1, 1, 8'h8F, 4'h8, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'hAB, 4'h8, 16'h00AB, 0, 1));
        vecs.push_back(mk(0, 1, 1, 8'hCD, 4'h8, 16'hCDAB, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'h8, OFF,      1, 0));
        // clr+LI during OPND discards byte
        vecs.push_back(mk(0, 1, 1, 8'hF0, 4'hF, 16'h0000, 0, 1));
        vecs.push_back(mk(1, 1, 1, 8'h12, 4'h0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h3A, 4'h3, 16'h000A, 1, 0));
        // opcode 7 is short, 8 is long (mask boundary)
        vecs.push_back(mk(0, 1, 1, 8'h7F, 4'h7, 16'h000F, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // EI is combinational: toggle mid-cycle with no edge
        @(negedge clk);
        LI = 1'b0; clr = 1'b0;
        EI = 1'b0;
        #1;
        check("ei_low_comb", '{op: 4'h7, add: OFF, rdy: 1'b1, need: 1'b0});
        EI = 1'b1;
        #1;
        check("ei_high_comb", '{op: 4'h7, add: 16'h000F, rdy: 1'b1, need: 1'b0});

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sap_ir_assembler.md
# sap_ir_assembler

Parametrised instruction register for the SAP-family CPU. It captures an opcode byte from the W bus and, for opcodes flagged as long, assembles one or more following operand bytes into a wide address/immediate field. It sits between the W bus and the controller/sequencer. It drives the opcode to the controller continuously and gates the address field back onto the bus under EI.

## Interface
- BUS_W, 8: width of the W bus and of each captured byte.
- OP_W, 4: opcode width, taken from IR_in[BUS_W-1 -: OP_W]. Constraint: 1 ≤ OP_W < BUS_W.
- ADDR_BYTES, 2: number of operand bytes for a long opcode. Constraint: ≥ 1. Derived ADDR_W = BUS_W*ADDR_BYTES.
- LONG_MASK, 16'hFF00: 2^OP_W bits. Bit k = 1 means opcode k is long.
- clk  in  1  single clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- LI  in  1  load strobe. IR_in is sampled at the rising edge while high.
- EI  in  1  enable IR_Add onto the bus.
- IR_in  in  BUS_W  byte from the W bus.
- IR_Add  out  ADDR_W  assembled address/immediate, gated by EI.
- IR_Op_code  out  OP_W  current opcode, always driven.
- IR_ready  out  1  complete instruction held.
- IR_need  out  1  operand byte expected next.

## Operation
- States: EMPTY, OPND, FULL. Reset state is EMPTY.
- Reset values:
  - Opcode register 0, address register 0, byte counter 0.
  - IR_ready 0, IR_need 0.
  - IR_Add is 0 when EI=1, and as defined under Configuration when EI=0.
- EMPTY or FULL, with LI=1 (opcode byte):
  - Opcode register ← IR_in top OP_W bits.
  - If LONG_MASK[opcode]=0: address ← zero-extended IR_in[BUS_W-OP_W-1:0]; next state FULL.
  - Otherwise: address ← 0, counter ← 0; next state OPND.
- OPND, with LI=1 (operand byte):
  - address[BUS_W*cnt +: BUS_W] ← IR_in, so bytes arrive little-endian.
  - cnt ← cnt+1.
  - When cnt == ADDR_BYTES-1, next state FULL.
- LI=0: all registers hold, in every state.
- Status outputs:
  - IR_ready = (state==FULL).
  - IR_need = (state==OPND).
- IR_Add with EI=1 drives the address register in every state. During OPND that value is only partially assembled. The controller must not consume it unless IR_ready=1.
- IR_Op_code is valid from the edge that captures the opcode byte, including throughout OPND.

## Timing
- All registers update on the rising edge. Outputs are registered, so new values are visible one edge after the byte is presented.
- Latency to IR_ready:
  - Short instruction: 1 cycle.
  - Long instruction: 1+ADDR_BYTES LI cycles. Idle cycles between bytes are permitted.
- clr has priority over LI. clr=1 with LI=1 results in the reset state, and the byte is discarded.
- clr during OPND aborts the partial instruction. The next LI byte is treated as an opcode byte.
- LI while in FULL starts a new instruction on the same edge, with no bubble. IR_ready stays 1 if the new opcode is short, and drops to 0 if it is long.
- Counter wrap-around cannot occur: the counter is cleared on every opcode capture and never exceeds ADDR_BYTES-1.
- EI is combinational to IR_Add. No clock latency.

## Configuration
- Macro SAP_IR_TRISTATE_EN.
- Defined: IR_Add is high-impedance when EI=0, for a shared tristate W bus.
- Undefined: IR_Add is driven to all zeros when EI=0, for an OR-muxed internal bus with no internal tristates.
- Register behaviour is identical in both builds.

## Structure
- Shared package sap_ir_pkg holds:
  - The state enum (EMPTY/OPND/FULL).
  - Default BUS_W/OP_W/ADDR_BYTES/LONG_MASK constants, reused by the controller's opcode decode.
  - The clog2-based counter width helper.
- One sub-module, sap_ir_opnd_shift: the byte-lane assembler. It holds the address register and counter and handles clear/zero-load/lane-write. The FSM and output gating stay in the top module.

## Test plan
Default parameters (BUS_W=8, OP_W=4, ADDR_BYTES=2, LONG_MASK=16'hFF00) are used throughout.
- clr=1 with LI=1, IR_in=8'h98, EI=1 → after the edge: IR_Op_code=0, IR_Add=16'h0000, IR_ready=0, IR_need=0.
- LI pulse with 8'h3A, then EI=1 → IR_Op_code=4'h3, IR_Add=16'h000A, IR_ready=1, IR_need=0.
- LI bytes 8'hC5, 8'h34, 8'h12, with idle cycles between them:
  - After the first byte: IR_Op_code=4'hC, IR_need=1, IR_ready=0. State holds across the idle cycles.
  - After the third byte: IR_Add=16'h1234, IR_ready=1.
- After 8'hC5, 8'h34, assert clr for 1 cycle, then LI 8'h27 → IR_Op_code=4'h2, IR_Add=16'h0007, IR_ready=1.
- From FULL (long instruction held), LI 8'h41 on the next cycle → IR_Op_code=4'h4, IR_Add=16'h0001, IR_ready stays 1 with no gap.
- EI=0 → IR_Add=16'hzzzz with SAP_IR_TRISTATE_EN defined, 16'h0000 without it. Re-raising EI restores the held value.
